// File: rtl/key_char_fifo.sv
// Maps keyboard make events to 8-bit character codes and buffers them in a show-ahead FIFO.
// Optional build macro CTRL_CODES_EN: Ctrl+letter is enqueued as its control code (char & 8'h1F).
module key_char_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  clrn,
   input  logic                  newKey,
   input  logic                  isASCIIkey,
   input  logic [7:0]            ASCII,
   input  logic [7:0]            scanCode,
   input  logic [7:0]            scanCode_E0,
   input  logic                  ctrl,
   input  logic                  rd_en,
   input  logic                  clr_ovf,
   output logic [7:0]            rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic [7:0]            drop_cnt
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [7:0]            map_chr;
   logic                  map_vld;
   logic [7:0]            stage_chr;
   logic                  stage_vld;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  pop;
   logic                  push;
   logic                  drop;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      map_vld = 1'b1;
      map_chr = 8'h00;
      if (isASCIIkey)                                   map_chr = ASCII;
      else if (scanCode == 8'h5A || scanCode_E0 == 8'h5A) map_chr = 8'h0A;
      else if (scanCode == 8'h66)                       map_chr = 8'h08;
      else if (scanCode == 8'h0D)                       map_chr = 8'h09;
      else if (scanCode == 8'h76)                       map_chr = 8'h1B;
      else                                              map_vld = 1'b0;
`ifdef CTRL_CODES_EN
      if (ctrl && ((map_chr >= 8'h41 && map_chr <= 8'h5A) ||
                   (map_chr >= 8'h61 && map_chr <= 8'h7A)))
         map_chr = map_chr & 8'h1F;
`endif
   end

`ifndef CTRL_CODES_EN
   logic unused_ctrl;
   assign unused_ctrl = ctrl;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stage_vld <= 1'b0;
         stage_chr <= 8'h00;
      end else begin
         stage_vld <= newKey && map_vld;
         if (newKey && map_vld) stage_chr <= map_chr;
      end
   end

   // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
   assign pop  = rd_en && !empty;
   assign push = stage_vld && (!full || pop);
   assign drop = stage_vld && full && !pop;

   // NOTE: the storage array has no reset; rd_data is masked while empty so stale RAM never shows.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= stage_chr;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         overflow <= 1'b0;
         drop_cnt <= 8'h00;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= 8'h00;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_key_char_fifo.sv
// Self-checking bench for key_char_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_key_char_fifo;

   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic              clk = 1'b0;
   logic              clrn = 1'b0;
   logic              newKey = 1'b0, isASCIIkey = 1'b0, ctrl = 1'b0, rd_en = 1'b0, clr_ovf = 1'b0;
   logic [7:0]        ASCII = 8'h00, scanCode = 8'h00, scanCode_E0 = 8'h00;
   logic [7:0]        rd_data, drop_cnt;
   logic              empty, full, overflow;
   logic [DEPTH_LOG2:0] count;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of stored characters plus the one-cycle mapping stage.
   logic [7:0] q[$];
   logic       m_vld = 1'b0;
   logic [7:0] m_chr = 8'h00;
   logic       m_ovf = 1'b0;
   int         m_drop = 0;

   key_char_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk(clk), .clrn(clrn), .newKey(newKey), .isASCIIkey(isASCIIkey), .ASCII(ASCII),
      .scanCode(scanCode), .scanCode_E0(scanCode_E0), .ctrl(ctrl), .rd_en(rd_en),
      .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ref_map(input logic isa, input logic [7:0] a,
                                          input logic [7:0] sc, input logic [7:0] sce,
                                          input logic ct);
      logic [7:0] c;
      logic       v;
      v = 1'b1;
      c = 8'h00;
      if (isa) c = a;
      else if (sc == 8'h5A || sce == 8'h5A) c = 8'h0A;
      else if (sc == 8'h66) c = 8'h08;
      else if (sc == 8'h0D) c = 8'h09;
      else if (sc == 8'h76) c = 8'h1B;
      else v = 1'b0;
`ifdef CTRL_CODES_EN
      if (v && ct && c >= "A" && c <= "Z") c = c - 8'h40;
      else if (v && ct && c >= "a" && c <= "z") c = c - 8'h60;
`else
      if (ct) c = c;
`endif
      return {v, c};
   endfunction

   function automatic logic [7:0] exp_head();
      return (q.size() > 0) ? q[0] : 8'h00;
   endfunction

   task automatic model_reset();
      q.delete();
      m_vld  = 1'b0;
      m_chr  = 8'h00;
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   task automatic model_edge();
      logic [8:0] mp;
      bit         do_pop, was_full, dropped;
      do_pop   = rd_en && (q.size() > 0);
      was_full = (q.size() == DEPTH);
      dropped  = 0;
      if (do_pop) void'(q.pop_front());
      if (m_vld) begin
         if (!was_full || do_pop) q.push_back(m_chr);
         else dropped = 1;
      end
      if (clr_ovf) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end else if (dropped) begin
         m_ovf = 1'b1;
         if (m_drop < 255) m_drop++;
      end
      mp    = ref_map(isASCIIkey, ASCII, scanCode, scanCode_E0, ctrl);
      m_vld = newKey && mp[8];
      m_chr = mp[7:0];
   endtask

   // Drives one clock of inputs from a negedge, advances the model at the posedge, returns at the next negedge.
   task automatic cycle(input logic nk, input logic isa, input logic [7:0] a, input logic [7:0] sc,
                        input logic [7:0] sce, input logic ct, input logic rd, input logic clr);
      newKey = nk; isASCIIkey = isa; ASCII = a; scanCode = sc; scanCode_E0 = sce;
      ctrl = ct; rd_en = rd; clr_ovf = clr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic key_asc(input logic [7:0] a, input logic ct);
      cycle(1'b1, 1'b1, a, 8'h00, 8'h00, ct, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if (count !== 5'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'h00)
         begin errors++; $display("FAIL reset_ovf: got %b/%h want 0/00", overflow, drop_cnt); end
      clrn = 1'b1;
   endtask

   task automatic test_first_char();
      key_asc(8'h61, 1'b0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_latency: empty=%b want 1 one clock after newKey", empty); end
      idle();
      checks++; if (empty !== 1'b0)    begin errors++; $display("FAIL first_empty: got %b want 0", empty); end
      checks++; if (rd_data !== 8'h61) begin errors++; $display("FAIL first_rd_data: got %h want 61", rd_data); end
      checks++; if (count !== 5'd1)    begin errors++; $display("FAIL first_count: got %0d want 1", count); end
      pop_one();
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL first_pop_empty: got %b want 1", empty); end
   endtask

   task automatic test_control_keys();
      logic [7:0] want [5];
      want = '{8'h0A, 8'h0A, 8'h08, 8'h09, 8'h1B};
      cycle(1'b1, 1'b0, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 8'h0D, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 8'h76, 8'h00, 1'b0, 1'b0, 1'b0);
      idle();
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL ctlkey_count: got %0d want 5", count); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (rd_data !== want[i])
            begin errors++; $display("FAIL ctlkey_pop%0d: got %h want %h", i, rd_data, want[i]); end
         pop_one();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ctlkey_empty: got %b want 1", empty); end
   endtask

   task automatic test_ignored_key();
      cycle(1'b1, 1'b0, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(); idle();
      checks++; if (empty !== 1'b1 || drop_cnt !== 8'h00 || overflow !== 1'b0)
         begin errors++; $display("FAIL ignored_key: empty=%b drop=%h ovf=%b want 1/00/0", empty, drop_cnt, overflow); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH + 3; i++) key_asc(8'h41 + 8'(i), 1'b0);
      idle();
      checks++; if (full !== 1'b1 || count !== 5'd16)
         begin errors++; $display("FAIL ovf_full: full=%b count=%0d want 1/16", full, count); end
      checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd3)
         begin errors++; $display("FAIL ovf_flags: ovf=%b drop=%0d want 1/3", overflow, drop_cnt); end
      checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL ovf_head: got %h want 41", rd_data); end
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0)
         begin errors++; $display("FAIL ovf_clear: ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
   endtask

   task automatic test_full_push_pop();
      key_asc(8'h7A, 1'b0);
      pop_one();
      checks++; if (count !== 5'd16 || overflow !== 1'b0)
         begin errors++; $display("FAIL fullpp_count: count=%0d ovf=%b want 16/0", count, overflow); end
      checks++; if (rd_data !== 8'h42) begin errors++; $display("FAIL fullpp_head: got %h want 42", rd_data); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (rd_data !== exp_head())
            begin errors++; $display("FAIL fullpp_drain%0d: got %h want %h", i, rd_data, exp_head()); end
         if (i == DEPTH - 1) begin
            checks++; if (rd_data !== 8'h7A) begin errors++; $display("FAIL fullpp_tail: got %h want 7a", rd_data); end
         end
         pop_one();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty: got %b want 1", empty); end
   endtask

   task automatic test_ctrl();
      logic [7:0] want;
`ifdef CTRL_CODES_EN
      want = 8'h03;
`else
      want = 8'h63;
`endif
      key_asc(8'h63, 1'b1);
      key_asc(8'h31, 1'b1);
      idle();
      checks++; if (rd_data !== want) begin errors++; $display("FAIL ctrl_letter: got %h want %h", rd_data, want); end
      pop_one();
      checks++; if (rd_data !== 8'h31) begin errors++; $display("FAIL ctrl_digit: got %h want 31", rd_data); end
      pop_one();
   endtask

   task automatic test_drop_saturate();
      for (int i = 0; i < DEPTH + 270; i++) key_asc(8'h30 + 8'(i % 10), 1'b0);
      idle();
      checks++; if (drop_cnt !== 8'hFF || overflow !== 1'b1)
         begin errors++; $display("FAIL drop_sat: drop=%h ovf=%b want ff/1", drop_cnt, overflow); end
      key_asc(8'h21, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (drop_cnt !== 8'h00 || overflow !== 1'b0)
         begin errors++; $display("FAIL clr_priority: drop=%h ovf=%b want 00/0", drop_cnt, overflow); end
   endtask

   task automatic test_reset_mid_burst();
      key_asc(8'h55, 1'b0);
      key_asc(8'h56, 1'b0);
      newKey = 1'b1; ASCII = 8'h57; isASCIIkey = 1'b1;
      #2 clrn = 1'b0;
      model_reset();
      #1;
      checks++; if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0)
         begin errors++; $display("FAIL midreset_now: empty=%b count=%0d full=%b want 1/0/0", empty, count, full); end
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'h00 || rd_data !== 8'h00)
         begin errors++; $display("FAIL midreset_flags: ovf=%b drop=%h rd=%h want 0/00/00", overflow, drop_cnt, rd_data); end
      newKey = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      idle(); idle();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midreset_stage: empty=%b want 1", empty); end
   endtask

   task automatic test_random();
      logic [7:0] codes [6];
      codes = '{8'h5A, 8'h66, 8'h0D, 8'h76, 8'h05, 8'h1C};
      for (int n = 0; n < 600; n++) begin
         logic       nk, isa, ct, rd, clr;
         logic [7:0] a, sc, sce;
         int         kind;
         nk   = ($urandom_range(0, 3) != 0);
         kind = $urandom_range(0, 3);
         isa  = (kind <= 1);
         a    = isa ? 8'($urandom_range(32, 126)) : 8'h00;
         sc   = (kind == 2) ? codes[$urandom_range(0, 5)] : 8'h00;
         sce  = (kind == 3) ? (($urandom_range(0, 1) != 0) ? 8'h5A : 8'h71) : 8'h00;
         ct   = ($urandom_range(0, 3) == 0);
         rd   = (n < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) != 0);
         clr  = ($urandom_range(0, 40) == 0);
         cycle(nk, isa, a, sc, sce, ct, rd, clr);
         checks++; if (rd_data !== exp_head() || count !== 5'(q.size()) ||
                       empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                       overflow !== m_ovf || drop_cnt !== 8'(m_drop))
            begin
               errors++;
               $display("FAIL random[%0d]: rd=%h cnt=%0d e=%b f=%b ovf=%b drop=%0d want rd=%h cnt=%0d ovf=%b drop=%0d",
                        n, rd_data, count, empty, full, overflow, drop_cnt, exp_head(), q.size(), m_ovf, m_drop);
            end
      end
   endtask

   initial begin
      test_reset();
      test_first_char();
      test_control_keys();
      test_ignored_key();
      test_overflow();
      test_full_push_pop();
      test_ctrl();
      test_drop_saturate();
      test_reset_mid_burst();
      test_random();
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
